prefix_sub_pipe: RTL and testbench

//  Pipelined parallel-prefix subtractor: diff = a - b - bin, with borrow-out and zero flag.
//  - Borrow dual of the group-generate (gray) cell: borrow-generate/borrow-propagate pairs
//    are merged over log2(WIDTH) Sklansky levels, with a register stage after each level.
//  - Sits beside the prefix adders in the arithmetic library.
//  - Feeds comparators and approximate-vs-exact error-measurement datapaths.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/prefix_level_reg.sv | 75 +++++++
 rtl/prefix_sub_pipe.sv | 137 +++++++++++++
 tb/tb_prefix_sub_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library helpers: constant log2 and the prefix-tree black cell.
package arith_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // (G,T) o (g,t) = (G | T&g, T&t); returns {G, T}
    function automatic logic [1:0] black_cell(input logic g_hi, input logic t_hi,
                                              input logic g_lo, input logic t_lo);
        return {g_hi | (t_hi & g_lo), t_hi & t_lo};
    endfunction

endpackage

// File: rtl/prefix_level_reg.sv
// One Sklansky level of the borrow prefix tree followed by enable-gated registers.
module prefix_level_reg
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LVL   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] t_in,
    input  logic [WIDTH-1:0] x_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] t_out,
    output logic [WIDTH-1:0] x_out
);

    logic [WIDTH-1:0] g_n;
    logic [WIDTH-1:0] t_n;
    logic [WIDTH-1:0] g_d, t_d, x_d;
    logic [WIDTH-1:0] g_q, t_q, x_q;
    logic             valid_d, valid_q;

    // Bits in the upper half of each 2^(LVL+1) group merge with the top bit of the lower half.
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        if (((j >> LVL) % 2) == 1) begin : g_black
            localparam int SRC = ((j >> LVL) << LVL) - 1;
            assign {g_n[j], t_n[j]} = black_cell(g_in[j], t_in[j], g_in[SRC], t_in[SRC]);
        end else begin : g_pass
            assign g_n[j] = g_in[j];
            assign t_n[j] = t_in[j];
        end
    end

    // Next-state: shift on enable, hold otherwise.
    always_comb begin
        g_d     = g_q;
        t_d     = t_q;
        x_d     = x_q;
        valid_d = valid_q;
        if (en) begin
            g_d     = g_n;
            t_d     = t_n;
            x_d     = x_in;
            valid_d = in_valid;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bit register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data registers; contents are don't-care while the valid bit is low.
    always_ff @(posedge clk) begin
        g_q <= g_d;
        t_q <= t_d;
        x_q <= x_d;
    end

    assign out_valid = valid_q;
    assign g_out     = g_q;
    assign t_out     = t_q;
    assign x_out     = x_q;

endmodule

// File: rtl/prefix_sub_pipe.sv
// Pipelined Sklansky prefix subtractor: diff = a - b - bin with borrow-out and zero flag.
module prefix_sub_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int LEVELS = clog2(WIDTH);

    logic             en;
    logic [WIDTH-1:0] s0_g_d, s0_t_d, s0_x_d;
    logic [WIDTH-1:0] s0_g_q, s0_t_q, s0_x_q;
    logic             s0_valid_d, s0_valid_q;

    logic [WIDTH-1:0] g_s [0:LEVELS];
    logic [WIDTH-1:0] t_s [0:LEVELS];
    logic [WIDTH-1:0] x_s [0:LEVELS];
    logic             v_s [0:LEVELS];

    logic [WIDTH-1:0] diff_d, diff_q;
    logic             bout_d, bout_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    // S0 terms. bin (bit -1, t=0) is folded into bit 0 here, and into x[0] so the
    // output stage only needs B[i-1] for i >= 1.
    always_comb begin
        s0_g_d     = s0_g_q;
        s0_t_d     = s0_t_q;
        s0_x_d     = s0_x_q;
        s0_valid_d = s0_valid_q;
        if (en) begin
            s0_g_d     = ~a & b;
            s0_t_d     = ~(a ^ b);
            s0_x_d     = a ^ b;
            s0_g_d[0]  = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & bin);
            s0_t_d[0]  = 1'b0;
            s0_x_d[0]  = a[0] ^ b[0] ^ bin;
            s0_valid_d = in_valid;
        end else begin
            s0_valid_d = s0_valid_q;
        end
    end

    // S0 valid register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
        end else begin
            s0_valid_q <= s0_valid_d;
        end
    end

    // S0 data registers.
    always_ff @(posedge clk) begin
        s0_g_q <= s0_g_d;
        s0_t_q <= s0_t_d;
        s0_x_q <= s0_x_d;
    end

    assign g_s[0] = s0_g_q;
    assign t_s[0] = s0_t_q;
    assign x_s[0] = s0_x_q;
    assign v_s[0] = s0_valid_q;

    for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_level
        prefix_level_reg #(
            .WIDTH (WIDTH),
            .LVL   (lvl)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (v_s[lvl]),
            .g_in      (g_s[lvl]),
            .t_in      (t_s[lvl]),
            .x_in      (x_s[lvl]),
            .out_valid (v_s[lvl+1]),
            .g_out     (g_s[lvl+1]),
            .t_out     (t_s[lvl+1]),
            .x_out     (x_s[lvl+1])
        );
    end

    // Output stage: after the last level g_s holds the borrow out of every bit.
    always_comb begin
        diff_d      = diff_q;
        bout_d      = bout_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (en) begin
            diff_d      = x_s[LEVELS] ^ {g_s[LEVELS][WIDTH-2:0], 1'b0};
            bout_d      = g_s[LEVELS][WIDTH-1];
            zero_d      = ~|(x_s[LEVELS] ^ {g_s[LEVELS][WIDTH-2:0], 1'b0});
            out_valid_d = v_s[LEVELS];
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output registers, fully cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= {WIDTH{1'b0}};
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// Directed-table and scoreboard bench for prefix_sub_pipe at WIDTH=16.
module tb_prefix_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        zero;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        zero;
    } vec_t;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        zero;
    } res_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cons  = 0;
    res_t exp_q[$];

    prefix_sub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        logic [16:0] r;
        res_t        o;
        r      = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        o.diff = r[15:0];
        o.bout = r[16];
        o.zero = (r[15:0] == 16'd0);
        return o;
    endfunction

    // One clock: inputs already driven at the negedge; scoreboard the handshakes of this cycle.
    task automatic step();
        res_t e;
        #1;
        if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
        if (out_valid && out_ready) begin
            n_cons++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_result: got diff 0x%0h, expected no result", diff);
            end else begin
                e = exp_q.pop_front();
                chk("sb_diff", {16'd0, diff}, {16'd0, e.diff});
                chk("sb_bout", {31'd0, bout}, {31'd0, e.bout});
                chk("sb_zero", {31'd0, zero}, {31'd0, e.zero});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends one beat and returns the number of edges until out_valid, counting the accepting edge.
    task automatic single_beat(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                               output int lat);
        a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    vec_t        tbl [0:9];
    logic [15:0] ra [0:9];
    logic [15:0] rb [0:9];
    logic        rbin [0:9];

    initial begin
        int          lat;
        int          sent;
        int          got0;
        int          cyc;
        logic [15:0] hold_diff;
        logic        hold_bout, hold_zero;
        logic        seen_bin, seen_bout, seen_zero, seen_stall_bubble;

        tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[7] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
        tbl[8] = '{16'h00FF, 16'h0100, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[9] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4A, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 16'd0; b = 16'd0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {16'd0, diff}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed table, one beat at a time.
        for (int i = 0; i < 10; i++) begin
            single_beat(tbl[i].a, tbl[i].b, tbl[i].bin, lat);
            chk("tbl_latency", lat, 32'd6);
            chk("tbl_diff", {16'd0, diff}, {16'd0, tbl[i].diff});
            chk("tbl_bout", {31'd0, bout}, {31'd0, tbl[i].bout});
            chk("tbl_zero", {31'd0, zero}, {31'd0, tbl[i].zero});
            step();
        end

        // Back-to-back stream of 10 beats with a 3-cycle downstream stall.
        for (int i = 0; i < 10; i++) begin
            ra[i] = 16'($urandom); rb[i] = 16'($urandom); rbin[i] = 1'($urandom);
        end
        sent = 0;
        got0 = n_cons;
        hold_diff = 16'd0; hold_bout = 1'b0; hold_zero = 1'b0;
        for (cyc = 0; cyc < 60 && (n_cons - got0) < 10; cyc++) begin
            out_ready = !(cyc >= 8 && cyc < 11);
            in_valid  = (sent < 10);
            if (sent < 10) begin
                a = ra[sent]; b = rb[sent]; bin = rbin[sent];
            end
            #1;
            if (cyc == 8) begin
                hold_diff = diff; hold_bout = bout; hold_zero = zero;
                chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            end
            if (cyc >= 8 && cyc < 11) begin
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_diff", {16'd0, diff}, {16'd0, hold_diff});
                chk("stall_bout", {31'd0, bout}, {31'd0, hold_bout});
                chk("stall_zero", {31'd0, zero}, {31'd0, hold_zero});
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        chk("stream_count", n_cons - got0, 32'd10);
        chk("stream_leftover", exp_q.size(), 32'd0);

        // Reset with 4 beats in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 16'(i * 7); b = 16'(i * 3 + 1); bin = 1'b1; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
            step();
        end
        single_beat(16'h0100, 16'h0001, 1'b0, lat);
        chk("midrst_latency", lat, 32'd6);
        chk("midrst_diff", {16'd0, diff}, 32'h0000_00FF);
        step();

        // Constrained-random run against the behavioural model.
        seen_bin = 1'b0; seen_bout = 1'b0; seen_zero = 1'b0; seen_stall_bubble = 1'b0;
        sent = 0;
        got0 = n_cons;
        in_valid = 1'b0;
        for (cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
            if (!in_valid) begin
                a = 16'($urandom);
                b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
                bin = 1'($urandom);
                if (a == b && $urandom_range(0, 1) == 0) bin = 1'b0;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                sent++;
                if (bin) seen_bin = 1'b1;
                if (model(a, b, bin).bout) seen_bout = 1'b1;
                if (model(a, b, bin).zero) seen_zero = 1'b1;
            end
            if (!in_valid && out_valid && !out_ready) seen_stall_bubble = 1'b1;
            step();
            in_valid = in_valid && !in_ready;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk("rand_sent", sent, 32'd10000);
        chk("rand_count", n_cons - got0, 32'd10000);
        chk("rand_leftover", exp_q.size(), 32'd0);
        chk("cov_bin", {31'd0, seen_bin}, 32'd1);
        chk("cov_bout", {31'd0, seen_bout}, 32'd1);
        chk("cov_zero", {31'd0, seen_zero}, 32'd1);
        chk("cov_stall_bubble", {31'd0, seen_stall_bubble}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
